// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  // Settle counter covers SETTLE values 0..15.
  localparam int unsigned SETTLE_W = 4;

  // One extra bit so a counter can hold the full table depth 2^n_in.
  function automatic int unsigned err_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/sweep_compare_lane.sv
// One checked channel: XOR compare against the golden bit plus a mismatch counter.
module sweep_compare_lane #(
  parameter int unsigned ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             dut_bit,
  input  logic             exp_bit,
  output logic [ERR_W-1:0] err_cnt,
  output logic             mismatch_c
);

  assign mismatch_c = dut_bit ^ exp_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
    end else if (sample_en && mismatch_c) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives vec 0..2^N_IN-1, checks N_CH channels
// against a captured golden truth table and reports counts and first failure.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [(1<<N_IN)-1:0]     golden,
  input  logic [N_CH-1:0]          dut_out,
  output logic [N_IN-1:0]          vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_CH*(N_IN+1)-1:0] err_cnt,
  output logic [N_IN-1:0]          first_fail_vec,
  output logic [N_CH-1:0]          first_fail_ch,
  output logic                     fail_seen
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned ERR_W = err_width(N_IN);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(DEPTH - 1);
  // With no settle time, each new vector is sampled on the very next edge.
  localparam state_t NEXT_VEC_ST = (SETTLE == 0) ? ST_SAMPLE : ST_APPLY;

  state_t              state;
  logic [DEPTH-1:0]    golden_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [N_CH-1:0]     mismatch_c;
  logic                clear_c;
  logic                sample_en_c;
  logic                exp_bit_c;

  assign clear_c     = (state == ST_IDLE) && start && !abort;
  assign sample_en_c = (state == ST_SAMPLE) && !abort;
  assign exp_bit_c   = golden_q[vec];

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    sweep_compare_lane #(.ERR_W(ERR_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear_c),
      .sample_en  (sample_en_c),
      .dut_bit    (dut_out[c]),
      .exp_bit    (exp_bit_c),
      .err_cnt    (err_cnt[c*ERR_W +: ERR_W]),
      .mismatch_c (mismatch_c[c])
    );
  end

  // Sweep control, vector/settle counters and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      golden_q       <= '0;
      settle_cnt     <= '0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      first_fail_vec <= '0;
      first_fail_ch  <= '0;
      fail_seen      <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            golden_q       <= golden;
            vec            <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            first_fail_vec <= '0;
            first_fail_ch  <= '0;
            fail_seen      <= 1'b0;
            state          <= NEXT_VEC_ST;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (!fail_seen && (|mismatch_c)) begin
            first_fail_vec <= vec;
            first_fail_ch  <= mismatch_c;
            fail_seen      <= 1'b1;
          end
          if (vec == VEC_LAST) begin
            state <= ST_FIN;
          end else begin
            vec   <= vec + N_IN'(1);
            state <= NEXT_VEC_ST;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          pass  <= ~|err_cnt;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
